gt_inhibit_array: RTL

//  N-channel clocked race-logic greater-than (inhibit) operator for the space-time datapath.
//  Per gamma cycle, each channel emits one PULSE_WIDTH-cycle pulse on q[i] iff a[i] arrives

---
 rtl/gt_inhibit_array.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gt_inhibit_array.sv
// N-channel race-logic greater-than (inhibit) operator with shared gamma counter.
// Optional arrival timestamps on port ts when GT_TIMESTAMP_EN is defined.
module gt_inhibit_array #(
    parameter int N_CH              = 4,
    parameter int PULSE_WIDTH       = 8,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter bit SHARED_INHIBIT    = 1'b0
) (
    input  logic                              aclk,
    input  logic                              grst,
    input  logic                              set,
    input  logic [N_CH-1:0]                   a,
    input  logic [N_CH-1:0]                   b,
    output logic [N_CH-1:0]                   q,
    output logic [N_CH-1:0]                   fired,
    output logic [N_CH-1:0]                   inhibited,
    output logic                              gamma_expired
`ifdef GT_TIMESTAMP_EN
    ,
    output logic [N_CH*GAMMA_CYCLE_WIDTH-1:0] ts
`endif
);

    localparam int GW  = GAMMA_CYCLE_WIDTH;
    localparam int PCW = $clog2(PULSE_WIDTH + 1);
    localparam logic [PCW-1:0] PW_LAST = PCW'(PULSE_WIDTH);
    localparam logic [GW-1:0]  GMAX    = {GW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_FIRING,
        ST_DONE,
        ST_INHIB
    } ch_state_t;

    logic [N_CH-1:0] a_d;
    logic [N_CH-1:0] b_d;
    logic [N_CH-1:0] a_rise;
    logic [N_CH-1:0] b_rise;
    logic [N_CH-1:0] b_hit;
    logic [GW-1:0]   gcnt;

    always_ff @(posedge aclk) begin
        if (grst) begin
            a_d <= '0;
            b_d <= '0;
        end else begin
            a_d <= a;
            b_d <= b;
        end
    end

    assign a_rise = a & ~a_d;
    assign b_rise = b & ~b_d;
    assign b_hit  = SHARED_INHIBIT ? {N_CH{b_rise[0]}} : b_rise;

    // Counter runs after reset too; channels stay IDLE until the first set.
    always_ff @(posedge aclk) begin
        if (grst) begin
            gcnt <= '0;
        end else if (set) begin
            gcnt <= '0;
        end else if (gcnt != GMAX) begin
            gcnt <= gcnt + 1'b1;
        end
    end

    assign gamma_expired = (gcnt == GMAX);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_t      st;
        logic           q_r;
        logic           fired_r;
        logic           inh_r;
        logic [PCW-1:0] pcnt;
`ifdef GT_TIMESTAMP_EN
        logic [GW-1:0]  ts_r;
`endif

        always_ff @(posedge aclk) begin
            if (grst) begin
                st      <= ST_IDLE;
                q_r     <= 1'b0;
                fired_r <= 1'b0;
                inh_r   <= 1'b0;
                pcnt    <= '0;
`ifdef GT_TIMESTAMP_EN
                ts_r    <= '0;
`endif
            end else if (set) begin
                st      <= ST_ARMED;
                q_r     <= 1'b0;
                fired_r <= 1'b0;
                inh_r   <= 1'b0;
                pcnt    <= '0;
`ifdef GT_TIMESTAMP_EN
                ts_r    <= '0;
`endif
            end else begin
                unique case (st)
                    ST_ARMED: begin
                        // Tie goes to the inhibitor.
                        if (b_hit[i]) begin
                            st    <= ST_INHIB;
                            inh_r <= 1'b1;
`ifdef GT_TIMESTAMP_EN
                            ts_r  <= GMAX;
`endif
                        end else if (a_rise[i]) begin
                            st      <= ST_FIRING;
                            q_r     <= 1'b1;
                            fired_r <= 1'b1;
                            pcnt    <= PCW'(1);
`ifdef GT_TIMESTAMP_EN
                            ts_r    <= gcnt;
`endif
                        end else if (gamma_expired) begin
                            st   <= ST_DONE;
`ifdef GT_TIMESTAMP_EN
                            ts_r <= GMAX;
`endif
                        end
                    end
                    ST_FIRING: begin
                        if (pcnt == PW_LAST) begin
                            st  <= ST_DONE;
                            q_r <= 1'b0;
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        assign q[i]         = q_r;
        assign fired[i]     = fired_r;
        assign inhibited[i] = inh_r;
`ifdef GT_TIMESTAMP_EN
        assign ts[i*GW +: GW] = ts_r;
`endif
    end

endmodule
